camera_capture_ctrl: RTL and testbench
======================================

// Module: camera_capture_ctrl
// PURPOSE
//  Frame-capture sequencer behind the pixel-byte assembler. Takes the 16-bit pixel
//  stream (data/valid plus registered hsync/vsync), arms on request, aligns to the
//  next frame start and issues frame-buffer write strobes with linear addresses.
//  Flags frame completion and line/frame geometry errors. Supports single-shot
//  and continuous capture.
// PARAMETERS
//  H_PIXELS    320  pixels per line written to the buffer
//  V_LINES     240  lines per frame written to the buffer
//  ADDR_WIDTH  17   write address width; must hold H_PIXELS*V_LINES-1
// PORTS
//  clk_pixel_in    in   1           system clock; all logic on rising edge
//  rst_in          in   1           synchronous reset, ACTIVE-LOW (0 = reset)
//  hs_cam_in       in   1           hsync from assembler, high = active line
//  vs_cam_in       in   1           vsync from assembler, high = active frame
//  data_in         in   16          assembled pixel
//  valid_in        in   1           1-cycle pixel strobe
//  capture_req_in  in   1           level/pulse: arm a capture when IDLE
//  continuous_in   in   1           1 = re-arm automatically after each frame
//  abort_in        in   1           return to IDLE, no frame_done
//  we_out          out  1           frame-buffer write enable
//  addr_out        out  ADDR_WIDTH  frame-buffer write address
//  pixel_out       out  16          frame-buffer write data
//  busy_out        out  1           high in ARMED/CAPTURE/DONE
//  frame_done_out  out  1           1-cycle pulse at end of captured frame
//  line_err_out    out  1           sticky: some line length != H_PIXELS
//  frame_err_out   out  1           sticky: line count != V_LINES
// BEHAVIOUR
//  Reset (rst_in=0): state IDLE; all outputs 0; counters 0; hs/vs prev regs 0.
//  Edge detect: hs_prev/vs_prev sampled every clk; rise = cur&~prev, fall = ~cur&prev.
//  States:
//   IDLE:    capture_req_in=1 -> ARMED; clear line_err/frame_err.
//   ARMED:   wait vs rise -> CAPTURE, hcount=vcount=addr=0. Pixels ignored.
//            Arming mid-frame never captures a partial frame.
//   CAPTURE: valid_in&hs_cam_in&hcount<H_PIXELS&vcount<V_LINES -> next cycle
//            we_out=1, pixel_out=data_in, addr_out=running addr; addr++, hcount++.
//            Pixels with hcount>=H_PIXELS or vcount>=V_LINES counted, not written.
//            hs fall with hcount!=0: if hcount!=H_PIXELS set line_err; vcount++
//            (saturate at V_LINES), hcount=0, addr=vcount_next*H_PIXELS.
//            hs fall with hcount==0 (blank line): ignored.
//            vs fall -> DONE; if vcount!=V_LINES set frame_err. vs fall and hs fall
//            same cycle: line close processed first, then vcount check.
//   DONE:    frame_done_out=1 for exactly this cycle; -> ARMED if continuous_in
//            else IDLE.
//  abort_in=1 in any state: -> IDLE next cycle, we_out=0, no frame_done; errors held.
//  abort_in has priority over capture_req_in and all edges.
//  Latency: valid_in -> we_out exactly 1 cycle; we_out never high 2 cycles
//  from a single valid_in. addr_out monotonic within a frame, max H*V-1.
//  busy_out = (state != IDLE), registered.
// TESTING
//  1 Single shot 4x3 (H_PIXELS=4,V_LINES=3): req, 3 lines x 4 px -> 12 we_out,
//    addr 0..11 in order, pixel_out==data_in, one frame_done, errs 0, then IDLE.
//  2 Arm mid-frame: req while vs high -> no we_out until next vs rise, then
//    full frame captured from addr 0.
//  3 Short line (3 px) then long line (6 px): line_err=1; long line writes 4 px
//    only; next line starts at addr 8; frame_err=0 if 3 lines total.
//  4 Short frame (2 lines) with continuous_in=1: frame_err=1, frame_done pulses,
//    state ARMED; second good frame writes addr 0..11, errs stay sticky.
//  5 abort_in mid-line after 2 px: IDLE next cycle, no further we_out, no
//    frame_done; rst_in=0 mid-frame -> all outputs 0 next cycle.
//  6 Simultaneous hs fall and vs fall on last line -> vcount==V_LINES, frame_err=0.

Source files
------------

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl
//   Frame-capture sequencer that sits behind the pixel-byte assembler.
//   It arms on request and waits for the next frame start (vsync rise).
//   It then writes each accepted pixel to a linear frame-buffer address,
//   pulses frame_done at the end of the frame and flags any line or frame
//   whose geometry is wrong. Capture can be single-shot or continuous.
//
// Ports
//   clk_pixel_in     clock, all logic on rising edge
//   rst_in           synchronous reset, active low
//   hs_cam_in        hsync, high = active line
//   vs_cam_in        vsync, high = active frame
//   data_in          assembled 16-bit pixel
//   valid_in         1-cycle pixel strobe
//   capture_req_in   arm a capture when idle
//   continuous_in    re-arm automatically after each frame
//   abort_in         return to idle immediately, no frame_done
//   we_out           frame-buffer write enable
//   addr_out         frame-buffer write address
//   pixel_out        frame-buffer write data
//   busy_out         high whenever not idle
//   frame_done_out   1-cycle pulse at end of a captured frame
//   line_err_out     sticky: some line length != H_PIXELS
//   frame_err_out    sticky: line count != V_LINES
//
// State    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | waiting for capture request
// S_ARMED  | waiting for vsync rise; pixels ignored
// S_CAPTURE| writing pixels, tracking line/frame geometry
// S_DONE   | one cycle, frame_done asserted
module camera_capture_ctrl #(
  parameter int H_PIXELS   = 320,
  parameter int V_LINES    = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic                  hs_cam_in,
  input  logic                  vs_cam_in,
  input  logic [15:0]           data_in,
  input  logic                  valid_in,
  input  logic                  capture_req_in,
  input  logic                  continuous_in,
  input  logic                  abort_in,
  output logic                  we_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [15:0]           pixel_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  line_err_out,
  output logic                  frame_err_out
);

  // hcount saturates at H_PIXELS+1: enough to tell a long line from a good one
  localparam int HCW = $clog2(H_PIXELS + 2);
  localparam int VCW = $clog2(V_LINES + 1);
  localparam logic [HCW-1:0] H_LEN = HCW'(H_PIXELS);
  localparam logic [HCW-1:0] H_SAT = HCW'(H_PIXELS + 1);
  localparam logic [VCW-1:0] V_LEN = VCW'(V_LINES);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_hs_prev;
  logic                  r_vs_prev;
  logic [HCW-1:0]        r_hcount;
  logic [VCW-1:0]        r_vcount;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr_out;
  logic [15:0]           r_pixel;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_line_err;
  logic                  r_frame_err;

  logic                  w_hs_fall;
  logic                  w_vs_rise;
  logic                  w_vs_fall;
  logic                  w_pix_in;
  logic                  w_pix_ok;
  logic                  w_line_close;
  logic [VCW-1:0]        w_vcount_next;

  assign w_hs_fall     = ~hs_cam_in & r_hs_prev;
  assign w_vs_rise     = vs_cam_in & ~r_vs_prev;
  assign w_vs_fall     = ~vs_cam_in & r_vs_prev;
  assign w_pix_in      = (r_state == S_CAPTURE) & valid_in & hs_cam_in;
  assign w_pix_ok      = w_pix_in & (r_hcount < H_LEN) & (r_vcount < V_LEN);
  // blank lines (hs pulse with no pixels) do not count as lines
  assign w_line_close  = (r_state == S_CAPTURE) & w_hs_fall & (r_hcount != '0);
  assign w_vcount_next = (w_line_close && r_vcount < V_LEN) ? r_vcount + VCW'(1) : r_vcount;

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort_in) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (capture_req_in) w_state_next = S_ARMED;
        S_ARMED:   if (w_vs_rise) w_state_next = S_CAPTURE;
        S_CAPTURE: if (w_vs_fall) w_state_next = S_DONE;
        S_DONE:    w_state_next = continuous_in ? S_ARMED : S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      r_hs_prev    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_addr_out   <= '0;
      r_pixel      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_hs_prev    <= hs_cam_in;
      r_vs_prev    <= vs_cam_in;
      r_we         <= 1'b0;
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (w_state_next == S_DONE);
      if (!abort_in) begin
        case (r_state)
          S_IDLE: begin
            if (capture_req_in) begin
              r_line_err  <= 1'b0;
              r_frame_err <= 1'b0;
            end
          end
          S_ARMED: begin
            if (w_vs_rise) begin
              r_hcount <= '0;
              r_vcount <= '0;
              r_addr   <= '0;
            end
          end
          S_CAPTURE: begin
            // a pixel and an hs fall cannot coincide (pixel needs hs high)
            if (w_pix_in && r_hcount != H_SAT) r_hcount <= r_hcount + HCW'(1);
            if (w_pix_ok) begin
              r_we       <= 1'b1;
              r_addr_out <= r_addr;
              r_pixel    <= data_in;
              r_addr     <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_line_close) begin
              if (r_hcount != H_LEN) r_line_err <= 1'b1;
              r_vcount <= w_vcount_next;
              r_hcount <= '0;
              // realign so a short line does not shift the following lines
              r_addr   <= ADDR_WIDTH'(w_vcount_next * H_PIXELS);
            end
            // uses the post-close count so a coincident hs fall is included
            if (w_vs_fall && w_vcount_next != V_LEN) r_frame_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign we_out         = r_we;
  assign addr_out       = r_addr_out;
  assign pixel_out      = r_pixel;
  assign busy_out       = r_busy;
  assign frame_done_out = r_frame_done;
  assign line_err_out   = r_line_err;
  assign frame_err_out  = r_frame_err;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
module tb_camera_capture_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int AW = 17;

  logic          clk_pixel_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          hs_cam_in = 1'b0;
  logic          vs_cam_in = 1'b0;
  logic [15:0]   data_in = '0;
  logic          valid_in = 1'b0;
  logic          capture_req_in = 1'b0;
  logic          continuous_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          we_out;
  logic [AW-1:0] addr_out;
  logic [15:0]   pixel_out;
  logic          busy_out;
  logic          frame_done_out;
  logic          line_err_out;
  logic          frame_err_out;

  camera_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_WIDTH(AW)) dut (
    .clk_pixel_in(clk_pixel_in), .rst_in(rst_in), .hs_cam_in(hs_cam_in),
    .vs_cam_in(vs_cam_in), .data_in(data_in), .valid_in(valid_in),
    .capture_req_in(capture_req_in), .continuous_in(continuous_in),
    .abort_in(abort_in), .we_out(we_out), .addr_out(addr_out),
    .pixel_out(pixel_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .line_err_out(line_err_out), .frame_err_out(frame_err_out));

  always #5 clk_pixel_in = ~clk_pixel_in;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   pix;
  } exp_t;

  typedef struct {
    int nl;
    int l0, l1, l2, l3;
    bit req;
    bit cont;
    bit exp_le;
    bit exp_fe;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   m_line = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write the DUT issues must match the oldest expectation
  always @(negedge clk_pixel_in) begin
    if (frame_done_out) n_done++;
    if (we_out) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_we: got write addr %0d, expected no write", addr_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (addr_out !== e.addr || pixel_out !== e.pix) begin
          n_fail++;
          $display("FAIL write: got addr %0d pix %0h expected addr %0d pix %0h",
                   addr_out, pixel_out, e.addr, e.pix);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel_in);
    #1;
  endtask

  task automatic send_line(input int len, input bit capt, input bit close_vs);
    exp_t e;
    hs_cam_in = 1'b1;
    tick();
    for (int p = 0; p < len; p++) begin
      valid_in = 1'b1;
      data_in  = 16'($urandom);
      if (capt && p < H && m_line < V) begin
        e.addr = AW'(m_line * H + p);
        e.pix  = data_in;
        q.push_back(e);
      end
      tick();
    end
    valid_in  = 1'b0;
    hs_cam_in = 1'b0;
    if (close_vs) vs_cam_in = 1'b0;
    tick();
    tick();
    if (capt && len > 0 && m_line < V) m_line++;
  endtask

  task automatic send_frame(input int nl, input int l0, input int l1, input int l2,
                            input int l3, input bit simul);
    int lens[4];
    lens = '{l0, l1, l2, l3};
    vs_cam_in = 1'b1;
    tick();
    tick();
    m_line = 0;
    for (int i = 0; i < nl; i++) send_line(lens[i], 1'b1, simul && (i == nl - 1));
    vs_cam_in = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic request();
    capture_req_in = 1'b1;
    tick();
    capture_req_in = 1'b0;
    tick();
  endtask

  vec_t vecs[6];
  int   done0;

  initial begin
    vecs[0] = '{nl:3, l0:4, l1:4, l2:4, l3:0, req:1, cont:0, exp_le:0, exp_fe:0};
    vecs[1] = '{nl:3, l0:3, l1:6, l2:4, l3:0, req:1, cont:0, exp_le:1, exp_fe:0};
    vecs[2] = '{nl:2, l0:4, l1:4, l2:0, l3:0, req:1, cont:1, exp_le:0, exp_fe:1};
    vecs[3] = '{nl:3, l0:4, l1:4, l2:4, l3:0, req:0, cont:0, exp_le:0, exp_fe:1};
    vecs[4] = '{nl:4, l0:4, l1:4, l2:4, l3:4, req:1, cont:0, exp_le:0, exp_fe:0};
    vecs[5] = '{nl:4, l0:4, l1:0, l2:4, l3:4, req:1, cont:0, exp_le:0, exp_fe:0};

    // reset state
    tick(); tick(); tick();
    chk("rst_we", we_out, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_pix", pixel_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", frame_done_out, 0);
    chk("rst_errs", {line_err_out, frame_err_out}, 0);
    rst_in = 1'b1;
    tick(); tick();

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      continuous_in = vecs[i].cont;
      if (vecs[i].req) begin
        request();
        chk($sformatf("v%0d_armed_busy", i), busy_out, 1);
        chk($sformatf("v%0d_errs_cleared", i), {line_err_out, frame_err_out}, 0);
      end
      done0 = n_done;
      send_frame(vecs[i].nl, vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3, 1'b0);
      chk($sformatf("v%0d_writes_left", i), q.size(), 0);
      chk($sformatf("v%0d_done", i), n_done - done0, 1);
      chk($sformatf("v%0d_line_err", i), line_err_out, vecs[i].exp_le);
      chk($sformatf("v%0d_frame_err", i), frame_err_out, vecs[i].exp_fe);
      chk($sformatf("v%0d_busy_after", i), busy_out, vecs[i].cont);
    end
    continuous_in = 1'b0;

    // arm mid-frame: the partial frame must not be captured
    vs_cam_in = 1'b1;
    tick(); tick();
    done0 = n_done;
    request();
    send_line(4, 1'b0, 1'b0);
    vs_cam_in = 1'b0;
    tick(); tick();
    chk("mid_no_done", n_done - done0, 0);
    chk("mid_still_armed", busy_out, 1);
    send_frame(3, 4, 4, 4, 0, 1'b0);
    chk("mid_writes_left", q.size(), 0);
    chk("mid_done", n_done - done0, 1);
    chk("mid_busy", busy_out, 0);

    // hs fall and vs fall together on the last line
    request();
    done0 = n_done;
    send_frame(3, 4, 4, 4, 0, 1'b1);
    chk("simul_writes_left", q.size(), 0);
    chk("simul_done", n_done - done0, 1);
    chk("simul_frame_err", frame_err_out, 0);
    chk("simul_line_err", line_err_out, 0);

    // abort after two pixels
    request();
    done0 = n_done;
    vs_cam_in = 1'b1;
    tick(); tick();
    hs_cam_in = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      exp_t e;
      valid_in = 1'b1;
      data_in  = 16'($urandom);
      e.addr = AW'(p);
      e.pix  = data_in;
      q.push_back(e);
      tick();
    end
    abort_in = 1'b1;
    data_in  = 16'($urandom);
    tick();
    abort_in = 1'b0;
    chk("abort_we", we_out, 0);
    chk("abort_busy", busy_out, 0);
    for (int p = 0; p < 2; p++) begin
      data_in = 16'($urandom);
      tick();
    end
    valid_in  = 1'b0;
    hs_cam_in = 1'b0;
    tick();
    vs_cam_in = 1'b0;
    tick(); tick(); tick();
    chk("abort_writes_left", q.size(), 0);
    chk("abort_no_done", n_done - done0, 0);
    chk("abort_idle", busy_out, 0);

    // reset in the middle of a captured line
    request();
    vs_cam_in = 1'b1;
    tick(); tick();
    hs_cam_in = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      exp_t e;
      valid_in = 1'b1;
      data_in  = 16'($urandom) | 16'h0100;
      e.addr = AW'(p);
      e.pix  = data_in;
      q.push_back(e);
      tick();
    end
    rst_in = 1'b0;
    tick();
    chk("mrst_we", we_out, 0);
    chk("mrst_addr", addr_out, 0);
    chk("mrst_pix", pixel_out, 0);
    chk("mrst_busy", busy_out, 0);
    chk("mrst_done", frame_done_out, 0);
    chk("mrst_writes_left", q.size(), 0);
    valid_in  = 1'b0;
    hs_cam_in = 1'b0;
    vs_cam_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick(); tick();
    chk("mrst_idle", busy_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
